alarm_clock: RTL and testbench

24-hour alarm clock with keypad entry, driving four ASCII display digits (HH:MM) and an alarm output. It contains a time-base generator, a 4-digit key shift buffer, a control FSM, a current-time counter, an alarm register and a display multiplexer/encoder. It is the top level of the alarm-clock design and connects directly to keypad, buttons and display.

---
 rtl/alarm_clock.sv | 165 ++++++++++++++++
 tb/tb_alarm_clock.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/alarm_clock.sv
// alarm_clock: 24-hour keypad alarm clock driving four ASCII digits and an alarm flag
module alarm_clock (
    input  logic       clock,
    input  logic       reset,
    input  logic       fastwatch,
    input  logic       alarm_button,
    input  logic       time_button,
    input  logic [3:0] key,
    output logic       alarm_sound,
    output logic [7:0] ms_hour,
    output logic [7:0] ls_hour,
    output logic [7:0] ms_minute,
    output logic [7:0] ls_minute
);
    typedef enum logic [2:0] {SHOW_TIME, KEY_STORED, KEY_WAITED, KEY_ENTRY, SHOW_ALARM} state_t;
    state_t state, next;
    logic [7:0] tick_cnt;
    logic [5:0] sec_cnt;
    logic [3:0] idle_cnt;
    logic one_second, one_minute, time_out, is_digit, shift, load_alarm, load_new_time, buf_valid, armed;
    logic [3:0] kb_mh, kb_lh, kb_mm, kb_lm;
    logic [3:0] cur_mh, cur_lh, cur_mm, cur_lm;
    logic [3:0] alm_mh, alm_lh, alm_mm, alm_lm;
    logic [15:0] disp;

    assign one_second = tick_cnt == 8'hFF;
    assign one_minute = one_second && (fastwatch || sec_cnt == 6'd59);
    assign time_out = idle_cnt == 4'd9;
    assign is_digit = key <= 4'd9;
    assign buf_valid = ((kb_mh < 4'd2 && kb_lh <= 4'd9) || (kb_mh == 4'd2 && kb_lh <= 4'd3))
                       && kb_mm <= 4'd5 && kb_lm <= 4'd9;

    // time base: 256-clock second pulse and a 0..59 second count for the minute pulse
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tick_cnt <= '0;
            sec_cnt  <= '0;
        end else begin
            tick_cnt <= tick_cnt + 8'd1;
            if (one_second)
                sec_cnt <= (sec_cnt == 6'd59) ? 6'd0 : sec_cnt + 6'd1;
        end
    end

    // inactivity seconds while entering keys; cleared in every non-entry state
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            idle_cnt <= '0;
        else if (state == KEY_ENTRY || state == KEY_WAITED) begin
            if (one_second)
                idle_cnt <= idle_cnt + 4'd1;
        end else
            idle_cnt <= '0;
    end

    // control state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            state <= SHOW_TIME;
        else
            state <= next;
    end

    // next state and one-cycle strobes
    always_comb begin
        next = state;
        shift = 1'b0;
        load_alarm = 1'b0;
        load_new_time = 1'b0;
        case (state)
            SHOW_TIME: begin
                if (alarm_button)
                    next = SHOW_ALARM;
                else if (is_digit)
                    next = KEY_STORED;
            end
            KEY_STORED: begin
                shift = 1'b1;
                next = KEY_WAITED;
            end
            KEY_WAITED: begin
                if (!is_digit)
                    next = KEY_ENTRY;
                else if (time_out)
                    next = SHOW_TIME;
            end
            KEY_ENTRY: begin
                if (alarm_button) begin
                    load_alarm = 1'b1;
                    next = SHOW_TIME;
                end else if (time_button) begin
                    load_new_time = 1'b1;
                    next = SHOW_TIME;
                end else if (time_out)
                    next = SHOW_TIME;
                else if (is_digit)
                    next = KEY_STORED;
            end
            SHOW_ALARM: begin
                if (!alarm_button)
                    next = SHOW_TIME;
            end
            default: next = SHOW_TIME;
        endcase
    end

    // key buffer shifts left, newest key enters at the least significant minute
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            {kb_mh, kb_lh, kb_mm, kb_lm} <= '0;
        else if (shift)
            {kb_mh, kb_lh, kb_mm, kb_lm} <= {kb_lh, kb_mm, kb_lm, key};
    end

    // current time: a valid load takes precedence over the minute increment
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            {cur_mh, cur_lh, cur_mm, cur_lm} <= '0;
        else if (load_new_time && buf_valid)
            {cur_mh, cur_lh, cur_mm, cur_lm} <= {kb_mh, kb_lh, kb_mm, kb_lm};
        else if (one_minute) begin
            if (cur_lm != 4'd9)
                cur_lm <= cur_lm + 4'd1;
            else begin
                cur_lm <= 4'd0;
                if (cur_mm != 4'd5)
                    cur_mm <= cur_mm + 4'd1;
                else begin
                    cur_mm <= 4'd0;
                    if (cur_mh == 4'd2 && cur_lh == 4'd3)
                        {cur_mh, cur_lh} <= '0;
                    else if (cur_lh == 4'd9) begin
                        cur_lh <= 4'd0;
                        cur_mh <= cur_mh + 4'd1;
                    end else
                        cur_lh <= cur_lh + 4'd1;
                end
            end
        end
    end

    // alarm register; armed once a valid alarm time has been committed
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            {alm_mh, alm_lh, alm_mm, alm_lm} <= '0;
            armed <= 1'b0;
        end else if (load_alarm && buf_valid) begin
            {alm_mh, alm_lh, alm_mm, alm_lm} <= {kb_mh, kb_lh, kb_mm, kb_lm};
            armed <= 1'b1;
        end
    end

    // display source: alarm view, key buffer during entry, otherwise current time
    always_comb begin
        disp = (state == SHOW_ALARM) ? {alm_mh, alm_lh, alm_mm, alm_lm} :
               (state == KEY_STORED || state == KEY_WAITED || state == KEY_ENTRY) ? {kb_mh, kb_lh, kb_mm, kb_lm} :
               {cur_mh, cur_lh, cur_mm, cur_lm};
    end

    assign ms_hour   = {4'h3, disp[15:12]};
    assign ls_hour   = {4'h3, disp[11:8]};
    assign ms_minute = {4'h3, disp[7:4]};
    assign ls_minute = {4'h3, disp[3:0]};
    assign alarm_sound = armed && {cur_mh, cur_lh, cur_mm, cur_lm} == {alm_mh, alm_lh, alm_mm, alm_lm};
endmodule

// File: tb/tb_alarm_clock.sv
// tb_alarm_clock: random and directed stimulus against a minutes-of-day reference model
module tb_alarm_clock;
    logic clock = 1'b0;
    logic reset = 1'b1;
    logic fastwatch = 1'b0;
    logic alarm_button = 1'b0;
    logic time_button = 1'b0;
    logic [3:0] key = 4'd10;
    logic alarm_sound;
    logic [7:0] ms_hour, ls_hour, ms_minute, ls_minute;

    alarm_clock dut (
        .clock(clock), .reset(reset), .fastwatch(fastwatch),
        .alarm_button(alarm_button), .time_button(time_button), .key(key),
        .alarm_sound(alarm_sound),
        .ms_hour(ms_hour), .ls_hour(ls_hour), .ms_minute(ms_minute), .ls_minute(ls_minute)
    );

    always #5 clock = ~clock;

    localparam int M_TIME = 0, M_STORED = 1, M_WAITED = 2, M_ENTRY = 3, M_ALARM = 4;
    int errors = 0, checks = 0;
    int m_mode, m_cyc, m_sec, m_idle, m_now, m_alm, m_armed;
    int m_buf[4];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] disp_now();
        return {ms_hour, ls_hour, ms_minute, ls_minute};
    endfunction

    function automatic int buf_val();
        int h, m;
        foreach (m_buf[i]) if (m_buf[i] > 9) return -1;
        h = m_buf[0] * 10 + m_buf[1];
        m = m_buf[2] * 10 + m_buf[3];
        return (h > 23 || m > 59) ? -1 : h * 60 + m;
    endfunction

    function automatic logic [31:0] exp_disp();
        int d[4];
        int t;
        if (m_mode == M_STORED || m_mode == M_WAITED || m_mode == M_ENTRY)
            d = m_buf;
        else begin
            t = (m_mode == M_ALARM) ? m_alm : m_now;
            d[0] = t / 600;
            d[1] = (t / 60) % 10;
            d[2] = (t % 60) / 10;
            d[3] = t % 10;
        end
        return {8'(48 + d[0]), 8'(48 + d[1]), 8'(48 + d[2]), 8'(48 + d[3])};
    endfunction

    task automatic model_reset();
        m_mode = M_TIME; m_cyc = 0; m_sec = 0; m_idle = 0;
        m_now = 0; m_alm = 0; m_armed = 0;
        m_buf = '{0, 0, 0, 0};
    endtask

    task automatic model_step();
        bit tick, minute, to, dig, ab, tbn, la, lt;
        int nmode, v;
        tick = m_cyc == 255;
        minute = tick && (fastwatch || m_sec == 59);
        to = m_idle == 9;
        dig = key <= 9;
        ab = alarm_button === 1'b1;
        tbn = time_button === 1'b1;
        la = 0; lt = 0;
        nmode = m_mode;
        case (m_mode)
            M_TIME:   if (ab) nmode = M_ALARM; else if (dig) nmode = M_STORED;
            M_STORED: nmode = M_WAITED;
            M_WAITED: if (!dig) nmode = M_ENTRY; else if (to) nmode = M_TIME;
            M_ENTRY: begin
                if (ab) begin la = 1; nmode = M_TIME; end
                else if (tbn) begin lt = 1; nmode = M_TIME; end
                else if (to) nmode = M_TIME;
                else if (dig) nmode = M_STORED;
            end
            default:  if (!ab) nmode = M_TIME;
        endcase
        v = buf_val();
        if (lt && v >= 0) m_now = v;
        else if (minute) m_now = (m_now + 1) % 1440;
        if (la && v >= 0) begin m_alm = v; m_armed = 1; end
        if (m_mode == M_STORED) begin
            m_buf[0] = m_buf[1]; m_buf[1] = m_buf[2]; m_buf[2] = m_buf[3]; m_buf[3] = int'(key);
        end
        if (m_mode == M_WAITED || m_mode == M_ENTRY) m_idle = m_idle + (tick ? 1 : 0);
        else m_idle = 0;
        if (tick) m_sec = (m_sec + 1) % 60;
        m_cyc = (m_cyc + 1) % 256;
        m_mode = nmode;
    endtask

    // one clock: compare at the falling edge, drive inputs, advance the model at the rising edge
    task automatic cyc(input int k, input bit ab, input bit tbn);
        @(negedge clock);
        check("display", disp_now(), exp_disp());
        check("alarm_sound", 32'(alarm_sound), 32'(m_armed != 0 && m_now == m_alm));
        reset = 1'b0;
        key = k[3:0];
        alarm_button = ab;
        time_button = tbn;
        @(posedge clock);
        model_step();
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        key = 4'd10; alarm_button = 1'b0; time_button = 1'b0;
        #1;
        check("reset_display", disp_now(), 32'h30303030);
        check("reset_alarm", 32'(alarm_sound), 32'd0);
        @(posedge clock);
        model_reset();
    endtask

    task automatic press(input int d, input int hold, input int gap);
        repeat (hold) cyc(d, 0, 0);
        repeat (gap) cyc(10, 0, 0);
    endtask

    task automatic enter4(input int a, input int b, input int c, input int d);
        press(a, 2, 1); press(b, 2, 1); press(c, 2, 1); press(d, 2, 1);
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(10, 0, 0);
    endtask

    task automatic wait_disp(input string tag, input logic [31:0] target, input int limit);
        bit hit = 0;
        for (int i = 0; i < limit && !hit; i++) begin
            cyc(10, 0, 0);
            #1;
            hit = disp_now() == target;
        end
        check(tag, 32'(hit), 32'd1);
    endtask

    initial begin
        model_reset();
        do_reset();
        press(1, 2, 1); press(2, 2, 1); press(3, 2, 1); press(5, 2, 1); press(9, 2, 1);
        cyc(10, 0, 1);
        #1 check("time_2359", disp_now(), 32'h32333539);
        enter4(0, 9, 2, 5);
        cyc(10, 1, 0);
        idle(2);
        repeat (3) cyc(10, 1, 0);
        #1 check("alarm_view", disp_now(), 32'h30393235);
        idle(2);
        enter4(0, 0, 0, 0);
        cyc(10, 1, 0);
        enter4(2, 3, 5, 9);
        cyc(10, 0, 1);
        fastwatch = 1'b1;
        wait_disp("wrap_to_0000", 32'h30303030, 300);
        check("alarm_at_0000", 32'(alarm_sound), 32'd1);
        wait_disp("reach_0001", 32'h30303031, 300);
        check("alarm_off_0001", 32'(alarm_sound), 32'd0);
        fastwatch = 1'b0;
        press(1, 2, 1);
        idle(10 * 256 + 20);
        enter4(2, 5, 0, 0);
        cyc(10, 0, 1);
        press(7, 3, 1);
        idle(3);
        press(4, 2, 0);
        do_reset();
        idle(3);
        repeat (1500) begin
            case ($urandom_range(0, 19))
                0, 1, 2, 3, 4, 5, 6, 7, 8, 9:
                    press($urandom_range(0, 9), $urandom_range(1, 3), $urandom_range(0, 2));
                10, 11: cyc(10, 0, 1);
                12, 13: repeat ($urandom_range(1, 4)) cyc(10, 1, 0);
                14: cyc($urandom_range(11, 15), 0, 0);
                15: fastwatch = ~fastwatch;
                16: cyc($urandom_range(0, 9), 1, 1);
                17, 18: idle($urandom_range(1, 300));
                default:
                    if ($urandom_range(0, 14) == 0) idle(2700);
                    else if ($urandom_range(0, 3) == 0) do_reset();
                    else idle(20);
            endcase
        end
        idle(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
